// File: rtl/sprite_line_render.sv
// rtl/sprite_line_render.sv - per-line sprite row fetch and pixel-aligned output for the colour mixer.
// Optional SPRITE_SCALE_EN adds a 2-bit scale input (S = 1 << scale).
module sprite_line_render #(
   parameter int CORDW  = 16,
   parameter int WIDTH  = 8,
   parameter int HEIGHT = 8,
   parameter int COLRW  = 4,
   parameter int TRANSP = 0,
   parameter int ADDRW  = 6
) (
   input  logic             clk_pix,
   input  logic             rst,
   input  logic             line,
   input  logic [CORDW-1:0] sx,
   input  logic [CORDW-1:0] sy,
   input  logic [CORDW-1:0] sprx,
   input  logic [CORDW-1:0] spry,
`ifdef SPRITE_SCALE_EN
   input  logic [1:0]       scale,
`endif
   input  logic [COLRW-1:0] data_in,
   output logic [ADDRW-1:0] pos,
   output logic [COLRW-1:0] pix,
   output logic             drawing,
   output logic             done
);

   localparam int RW   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
   localparam int OFFW = $clog2(WIDTH * 8) + 1;
   localparam logic signed [CORDW:0] LEAD = (CORDW+1)'(3);

   typedef enum logic [2:0] {IDLE, REG_POS, ACTIVE, SPR_LINE, WAIT_DATA} state_t;

   state_t           state_q, state_d;
   logic [CORDW-1:0] sprx_q, sprx_d, spry_q, spry_d;
   logic [1:0]       scale_q, scale_d, scale_in;
   logic [RW-1:0]    row_q, row_d;
   logic             last_row_q, last_row_d;
   logic [OFFW-1:0]  off_q, off_d;
   logic             wait_q, wait_d;
   logic             v1_q, v1_d;
   logic [COLRW-1:0] pix_q, pix_d;
   logic             drawing_q, drawing_d;
   logic             done_q, done_d;

   logic signed [CORDW:0] sx_e, sy_e, sprx_e, spry_e, dy, lead, hspan, row_full;
   logic [OFFW-1:0]       span, off_iss, col;
   logic [ADDRW-1:0]      row_base;
   logic                  issue;

`ifdef SPRITE_SCALE_EN
   assign scale_in = scale;
`else
   assign scale_in = 2'd0;
`endif

   always_comb begin
      state_d    = state_q;
      sprx_d     = sprx_q;
      spry_d     = spry_q;
      scale_d    = scale_q;
      row_d      = row_q;
      last_row_d = last_row_q;
      off_d      = off_q;
      wait_d     = wait_q;
      done_d     = 1'b0;
      issue      = 1'b0;
      off_iss    = '0;
      pos        = '0;

      // Sign-extend by one bit so range and lead compares cannot overflow.
      sx_e     = $signed({sx[CORDW-1], sx});
      sy_e     = $signed({sy[CORDW-1], sy});
      sprx_e   = $signed({sprx_q[CORDW-1], sprx_q});
      spry_e   = $signed({spry_q[CORDW-1], spry_q});
      dy       = sy_e - spry_e;
      lead     = sprx_e - sx_e;
      hspan    = (CORDW+1)'(HEIGHT) << scale_q;
      span     = OFFW'(WIDTH) << scale_q;
      row_full = dy >>> scale_q;

      case (state_q)
         REG_POS: begin
            // sx here is line sx + 1, so a lead of 3 means sprx >= line sx + 4.
            if (!dy[CORDW] && (dy < hspan) && (lead >= LEAD)) begin
               state_d    = ACTIVE;
               row_d      = row_full[RW-1:0];
               last_row_d = (dy == hspan - (CORDW+1)'(1));
            end else begin
               state_d = IDLE;
            end
         end
         ACTIVE: begin
            if (sx_e + (CORDW+1)'(2) == sprx_e) begin
               issue   = 1'b1;
               off_iss = '0;
            end
         end
         SPR_LINE: begin
            issue   = 1'b1;
            off_iss = off_q;
         end
         WAIT_DATA: begin
            // Two cycles so done lands just after the last pixel leaves pix.
            if (wait_q) begin
               state_d = IDLE;
               done_d  = last_row_q;
            end else begin
               wait_d = 1'b1;
            end
         end
         default: ;
      endcase

      if (issue) begin
         off_d = off_iss + OFFW'(1);
         if (off_iss == span - OFFW'(1)) begin
            state_d = WAIT_DATA;
            wait_d  = 1'b0;
         end else begin
            state_d = SPR_LINE;
         end
      end

      if (line) begin
         state_d = REG_POS;
         sprx_d  = sprx;
         spry_d  = spry;
         scale_d = scale_in;
         issue   = 1'b0;
         done_d  = 1'b0;
      end

      col      = off_iss >> scale_q;
      row_base = ADDRW'(row_q) * ADDRW'(WIDTH);
      if (issue) begin
         pos = row_base + ADDRW'(col);
      end

      v1_d      = issue;
      pix_d     = v1_q ? data_in : '0;
      drawing_d = v1_q && (data_in != COLRW'(TRANSP));
   end

   always_ff @(posedge clk_pix) begin
      if (rst) begin
         state_q    <= IDLE;
         sprx_q     <= '0;
         spry_q     <= '0;
         scale_q    <= '0;
         row_q      <= '0;
         last_row_q <= 1'b0;
         off_q      <= '0;
         wait_q     <= 1'b0;
         v1_q       <= 1'b0;
         pix_q      <= '0;
         drawing_q  <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         sprx_q     <= sprx_d;
         spry_q     <= spry_d;
         scale_q    <= scale_d;
         row_q      <= row_d;
         last_row_q <= last_row_d;
         off_q      <= off_d;
         wait_q     <= wait_d;
         v1_q       <= v1_d;
         pix_q      <= pix_d;
         drawing_q  <= drawing_d;
         done_q     <= done_d;
      end
   end

   assign pix     = pix_q;
   assign drawing = drawing_q;
   assign done    = done_q;

endmodule

// File: tb/tb_sprite_line_render.sv
// tb/tb_sprite_line_render.sv - directed line-by-line bench with a scoreboard of expected outputs.
module tb_sprite_line_render;

   logic        clk_pix = 1'b0;
   logic        rst;
   logic        line;
   logic [15:0] sx, sy, sprx, spry;
   logic [3:0]  data_in = 4'd0;
   logic [5:0]  pos;
   logic [3:0]  pix;
   logic        drawing, done;
`ifdef SPRITE_SCALE_EN
   logic [1:0]  scale = 2'd0;
`endif

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [3:0] pix;
      logic       drawing;
      logic       done;
      logic [5:0] pos;
   } exp_t;
   exp_t sb[$];

   sprite_line_render dut (
      .clk_pix (clk_pix),
      .rst     (rst),
      .line    (line),
      .sx      (sx),
      .sy      (sy),
      .sprx    (sprx),
      .spry    (spry),
`ifdef SPRITE_SCALE_EN
      .scale   (scale),
`endif
      .data_in (data_in),
      .pos     (pos),
      .pix     (pix),
      .drawing (drawing),
      .done    (done)
   );

   always #5 clk_pix = ~clk_pix;

   // Synchronous ROM model: ROM[a] = a[3:0].
   always @(posedge clk_pix) data_in <= pos[3:0];

   task automatic check_out(input string tag, input int x);
      exp_t e;
      e = sb.pop_front();
      checks++;
      assert (pix === e.pix) else begin
         failures++;
         $error("FAIL %s pix sx=%0d got=%0d exp=%0d", tag, x, pix, e.pix);
      end
      checks++;
      assert (drawing === e.drawing) else begin
         failures++;
         $error("FAIL %s drawing sx=%0d got=%0b exp=%0b", tag, x, drawing, e.drawing);
      end
      checks++;
      assert (done === e.done) else begin
         failures++;
         $error("FAIL %s done sx=%0d got=%0b exp=%0b", tag, x, done, e.done);
      end
      checks++;
      assert (pos === e.pos) else begin
         failures++;
         $error("FAIL %s pos sx=%0d got=%0d exp=%0d", tag, x, pos, e.pos);
      end
   endtask

   // One display line: line pulse at sx=l0, sx counts up until past the sprite end.
   task automatic do_line(input string tag, input int y, input int l0,
                          input int chg_sx, input int chg_val, input int rst_sx);
      int   lsprx, row, ncyc, x, k, k2;
      bit   hit, alive;
      exp_t e;
      lsprx = int'($signed(sprx));
      row   = y - int'($signed(spry));
      hit   = (row >= 0) && (row < 8) && (lsprx - l0 >= 4);
      ncyc  = lsprx + 10 - l0;
      for (int c = 0; c < ncyc; c++) begin
         @(posedge clk_pix);
         #1;
         x     = l0 + c;
         sx    = 16'(x);
         sy    = 16'(y);
         line  = (c == 0);
         rst   = (x == rst_sx);
         if (x == chg_sx) sprx = 16'(chg_val);
         alive = (rst_sx < 0) || (x <= rst_sx);
         k     = x - lsprx;
         k2    = k + 2;
         e.pix     = (hit && alive && k >= 0 && k < 8) ? 4'((row * 8 + k) % 16) : 4'd0;
         e.drawing = (e.pix != 4'd0);
         e.done    = hit && alive && (row == 7) && (k == 8);
         e.pos     = (hit && alive && k2 >= 0 && k2 < 8) ? 6'(row * 8 + k2) : 6'd0;
         sb.push_back(e);
         #1;
         check_out(tag, x);
      end
      line = 1'b0;
      rst  = 1'b0;
   endtask

   initial begin
      exp_t e0;
      rst  = 1'b1;
      line = 1'b0;
      sx   = '0;
      sy   = '0;
      sprx = 16'd100;
      spry = 16'd50;
      repeat (3) @(posedge clk_pix);
      #1;
      e0 = '0;
      sb.push_back(e0);
      check_out("reset", 0);
      rst = 1'b0;

      do_line("row0", 50, 90, -1, 0, -1);
      do_line("row7", 57, 90, -1, 0, -1);
      do_line("below", 58, 90, -1, 0, -1);
      do_line("sprx_chg", 52, 90, 104, 200, -1);
      do_line("sprx_new", 53, 90, -1, 0, -1);
      sprx = 16'd100;
      do_line("mid_rst", 51, 90, -1, 0, 103);
      do_line("post_rst", 52, 90, -1, 0, -1);
      do_line("lead2", 50, 98, -1, 0, -1);
      do_line("lead4", 50, 96, -1, 0, -1);
      spry = 16'hFFFE;
      sprx = 16'hFFF8;
      do_line("neg_xy", 3, -20, -1, 0, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
